// File: rtl/counter_updown_mod.sv
// Parametrised up/down counter with runtime modulus, step size, parallel load,
// wrap or saturate mode, registered carry/borrow pulses and a terminal-count flag.
module counter_updown_mod #(
  parameter int WIDTH    = 8,
  parameter int STEP_W   = 4,
  parameter int SATURATE = 0
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              en,
  input  logic              updown,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  limit,
  input  logic              load,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  q,
  output logic              carry,
  output logic              borrow,
  output logic              tc,
  output logic              zero
);

  localparam int XW = WIDTH + 1;
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;

  // Range decisions use one extra bit so q+step never overflows.
  logic [XW-1:0]    q_x, lim_x, step_x, sum_x;
  logic [WIDTH-1:0] step_w;
  logic             oversized;

  assign q_x       = {1'b0, q_q};
  assign lim_x     = {1'b0, limit};
  assign step_x    = XW'(step);
  assign step_w    = WIDTH'(step);
  assign sum_x     = q_x + step_x;
  assign oversized = (step_x > lim_x);

  // Results written back are known to lie in 0..limit, so WIDTH-bit
  // modular arithmetic yields the exact value.
  always_comb begin
    q_d      = q_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    if (load) begin
      q_d = din;
    end else if (en && (step != '0)) begin
      if (q_x > lim_x) begin
        if (updown) begin
          q_d     = '0;
          carry_d = 1'b1;
        end else begin
          q_d      = limit;
          borrow_d = 1'b1;
        end
      end else if (updown) begin
        if (sum_x <= lim_x) begin
          q_d = q_q + step_w;
        end else begin
          carry_d = 1'b1;
          if (SATURATE != 0)  q_d = limit;
          else if (oversized) q_d = '0;
          else                q_d = q_q + step_w - limit - ONE_W;
        end
      end else begin
        if (q_x >= step_x) begin
          q_d = q_q - step_w;
        end else begin
          borrow_d = 1'b1;
          if (SATURATE != 0)  q_d = '0;
          else if (oversized) q_d = limit;
          else                q_d = q_q + limit + ONE_W - step_w;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      q_q      <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end
  end

  assign q      = q_q;
  assign carry  = carry_q;
  assign borrow = borrow_q;
  assign tc     = (updown & (q_q == limit)) | (~updown & (q_q == '0));
  assign zero   = (q_q == '0);

endmodule

// File: tb/tb_counter_updown_mod.sv
// Table-driven bench for counter_updown_mod: one wrap-mode and one saturate-mode
// instance share stimulus; each vector names which instance it checks.
module tb_counter_updown_mod;

  logic       clk;
  logic       clr_n, en, updown, load;
  logic [3:0] step, limit, din;
  logic [3:0] q_w, q_s;
  logic       carry_w, borrow_w, tc_w, zero_w;
  logic       carry_s, borrow_s, tc_s, zero_s;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       clr_n, load, en, updown, sat;
    logic [3:0] step, limit, din;
    logic [3:0] eq;
    logic       ec, eb, etc, ez;
  } vec_t;

  vec_t vecs[$];

  counter_updown_mod #(.WIDTH(4), .STEP_W(4), .SATURATE(0)) dut_wrap (
    .clk(clk), .clr_n(clr_n), .en(en), .updown(updown), .step(step),
    .limit(limit), .load(load), .din(din),
    .q(q_w), .carry(carry_w), .borrow(borrow_w), .tc(tc_w), .zero(zero_w)
  );

  counter_updown_mod #(.WIDTH(4), .STEP_W(4), .SATURATE(1)) dut_sat (
    .clk(clk), .clr_n(clr_n), .en(en), .updown(updown), .step(step),
    .limit(limit), .load(load), .din(din),
    .q(q_s), .carry(carry_s), .borrow(borrow_s), .tc(tc_s), .zero(zero_s)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic c, input logic ld, input logic e,
                              input logic ud, input logic [3:0] st,
                              input logic [3:0] lim, input logic [3:0] d,
                              input logic sat, input logic [3:0] eq,
                              input logic ec, input logic eb,
                              input logic etc, input logic ez);
    vec_t v;
    v.clr_n = c;  v.load = ld; v.en = e; v.updown = ud; v.sat = sat;
    v.step = st; v.limit = lim; v.din = d;
    v.eq = eq; v.ec = ec; v.eb = eb; v.etc = etc; v.ez = ez;
    return v;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  // driver: apply one vector, clock it, compare 1 time unit after the edge
  task automatic run_vec(input vec_t v, input int idx);
    clr_n  = v.clr_n;
    load   = v.load;
    en     = v.en;
    updown = v.updown;
    step   = v.step;
    limit  = v.limit;
    din    = v.din;
    @(posedge clk);
    #1;
    if (v.sat) begin
      check("q_sat",      idx, q_s,             v.eq);
      check("carry_sat",  idx, {3'b0, carry_s},  {3'b0, v.ec});
      check("borrow_sat", idx, {3'b0, borrow_s}, {3'b0, v.eb});
      check("tc_sat",     idx, {3'b0, tc_s},     {3'b0, v.etc});
      check("zero_sat",   idx, {3'b0, zero_s},   {3'b0, v.ez});
    end else begin
      check("q",      idx, q_w,             v.eq);
      check("carry",  idx, {3'b0, carry_w},  {3'b0, v.ec});
      check("borrow", idx, {3'b0, borrow_w}, {3'b0, v.eb});
      check("tc",     idx, {3'b0, tc_w},     {3'b0, v.etc});
      check("zero",   idx, {3'b0, zero_w},   {3'b0, v.ez});
    end
  endtask

  initial begin
    clr_n = 1'b0; load = 1'b0; en = 1'b0; updown = 1'b1;
    step = 4'd1; limit = 4'd15; din = 4'd0;

    //            clr ld en ud stp lim din sat  q  c  b  tc z
    // reset, count to 5, reset overriding load, then count again
    vecs.push_back(mk(0, 0, 0, 1, 1, 15, 0, 0,   0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 15, 0, 1,   0, 0, 0, 1, 1));
    for (int i = 1; i <= 5; i++)
      vecs.push_back(mk(1, 0, 1, 1, 1, 15, 0, 0, 4'(i), 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 1, 15, 9, 0,   0, 0, 0, 0, 1));
    for (int i = 1; i <= 3; i++)
      vecs.push_back(mk(1, 0, 1, 1, 1, 15, 0, 0, 4'(i), 0, 0, 0, 0));
    // wrap up, limit 9 step 3 from 8
    vecs.push_back(mk(1, 1, 0, 1, 3, 9, 8, 0,    8, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, 3, 9, 0, 0,    1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, 3, 9, 0, 0,    4, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, 3, 9, 0, 0,    7, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, 3, 9, 0, 0,    0, 1, 0, 0, 1));
    // wrap down from 1
    vecs.push_back(mk(1, 1, 0, 0, 3, 9, 1, 0,    1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 3, 9, 0, 0,    8, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 3, 9, 0, 0,    5, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 3, 9, 0, 0,    2, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 3, 9, 0, 0,    9, 0, 1, 0, 0));
    // out of range after load
    vecs.push_back(mk(1, 1, 0, 1, 3, 9, 14, 0,  14, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, 3, 9, 0, 0,    0, 1, 0, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 3, 9, 14, 0,  14, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 3, 9, 0, 0,    9, 0, 1, 0, 0));
    // hold: en=0, then step=0
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1, 0, 0, 1, 3, 9, 0, 0,  9, 0, 0, 1, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1, 0, 1, 1, 0, 9, 0, 0,  9, 0, 0, 1, 0));
    // down-count terminal count at zero, then limit=0
    vecs.push_back(mk(1, 1, 0, 0, 1, 9, 0, 0,    0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 0, 1, 1, 1, 0, 0, 0,    0, 1, 0, 1, 1));
    vecs.push_back(mk(1, 0, 1, 0, 1, 0, 0, 0,    0, 0, 1, 1, 1));
    // oversized step, wrap mode
    vecs.push_back(mk(1, 1, 0, 1, 9, 3, 2, 0,    2, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, 9, 3, 0, 0,    0, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 1, 0, 9, 3, 0, 0,    3, 0, 1, 0, 0));
    // load and en together: load wins, no pulse
    vecs.push_back(mk(1, 1, 1, 1, 1, 9, 5, 0,    5, 0, 0, 0, 0));
    // saturate mode
    vecs.push_back(mk(1, 1, 0, 1, 5, 12, 10, 1, 10, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, 5, 12, 0, 1,  12, 1, 0, 1, 0));
    vecs.push_back(mk(1, 0, 1, 1, 5, 12, 0, 1,  12, 1, 0, 1, 0));
    vecs.push_back(mk(1, 0, 1, 0, 5, 12, 0, 1,   7, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 5, 12, 0, 1,   2, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 5, 12, 0, 1,   0, 0, 1, 1, 1));
    vecs.push_back(mk(1, 0, 1, 0, 5, 12, 0, 1,   0, 0, 1, 1, 1));
    // saturate mode out of range, both directions
    vecs.push_back(mk(1, 1, 0, 1, 5, 12, 14, 1, 14, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, 5, 12, 0, 1,   0, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 1, 5, 12, 0, 1,   0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 5, 12, 14, 1, 14, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 5, 12, 0, 1,  12, 0, 1, 0, 0));

    for (int i = 0; i < vecs.size(); i++)
      run_vec(vecs[i], i);

    // limit lowered below q on the counting edge, then pulse must drop
    run_vec(mk(1, 1, 0, 1, 1, 9, 5, 0,  5, 0, 0, 0, 0), 100);
    run_vec(mk(1, 0, 1, 1, 1, 3, 0, 0,  0, 1, 0, 0, 1), 101);
    run_vec(mk(1, 0, 0, 1, 1, 3, 0, 0,  0, 0, 0, 0, 1), 102);

    // tc follows updown and limit with no clock edge
    run_vec(mk(1, 1, 0, 0, 1, 9, 0, 0,  0, 0, 0, 1, 1), 103);
    updown = 1'b1;
    #1;
    check("tc_comb_up", 104, {3'b0, tc_w}, 4'd0);
    limit = 4'd0;
    #1;
    check("tc_comb_lim0", 105, {3'b0, tc_w}, 4'd1);
    check("zero_comb", 105, {3'b0, zero_w}, 4'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_updown_mod.md
# counter_updown_mod

Parametrised up/down counter: the next generation of the team's 4-bit up/down counter. It adds a configurable width, a programmable runtime modulus, a step size, parallel load, count enable, and wrap or saturate mode. Registered carry/borrow pulses and a terminal-count flag let counters be cascaded, and let the block act as a programmable timebase or position counter inside larger datapaths.

## Interface
- WIDTH, 8: counter width in bits; legal range 2..32.
- STEP_W, 4: width of the step input; must be <= WIDTH.
- SATURATE, 0: 0 = wrap at the modulus, 1 = saturate at 0 / limit.
- clk  input  1  rising-edge clock; all state changes on this edge.
- clr_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- en  input  1  count enable.
- updown  input  1  direction: 1 = count up, 0 = count down.
- step  input  STEP_W  increment/decrement amount per enabled cycle; 0 = hold.
- limit  input  WIDTH  count range is 0..limit inclusive (modulus limit+1).
- load  input  1  parallel load strobe.
- din  input  WIDTH  parallel load value.
- q  output  WIDTH  counter value, registered.
- carry  output  1  one-cycle registered pulse: an up count wrapped or saturated.
- borrow  output  1  one-cycle registered pulse: a down count wrapped or saturated.
- tc  output  1  combinational terminal count: (updown & q==limit) | (~updown & q==0).
- zero  output  1  combinational, q==0.

## Operation
- Per-edge priority: clr_n low > load > en&&step!=0 > hold.
- Reset (clr_n=0): q=0, carry=0, borrow=0. Consequently zero=1, and tc=1 when updown=0 or limit=0.
- Load: q=din, carry=borrow=0. din > limit is accepted unchanged.
- Hold (en=0 or step=0): q is unchanged; carry=borrow=0.
- Arithmetic uses WIDTH+1 bits internally. step is zero-extended, and no overflow is lost.
- Up count, q<=limit:
  - q+step<=limit: q=q+step.
  - Otherwise, wrap mode: q=q+step-(limit+1), carry=1.
  - Otherwise, saturate mode: q=limit, carry=1.
- Down count, q<=limit:
  - q>=step: q=q-step.
  - Otherwise, wrap mode: q=q+(limit+1)-step, borrow=1.
  - Otherwise, saturate mode: q=0, borrow=1.
- Oversized step (step>limit, limit+1 not a multiple):
  - Up: q=0 with carry=1 in wrap mode; q=limit with carry=1 in saturate mode.
  - Down: q=limit with borrow=1 in wrap mode; q=0 with borrow=1 in saturate mode.
  - This case is a decided simplification; no modulo division is performed.
- Out of range (q>limit, e.g. after load or after limit is lowered):
  - Next enabled up count: q=0, carry=1.
  - Next enabled down count: q=limit, borrow=1.
  - This applies in both modes.
- Saturate mode at a bound:
  - Up count while q==limit: q stays at limit and carry=1 every enabled cycle.
  - Down count while q==0: q stays at 0 and borrow=1 every enabled cycle.
- limit=0: q stays 0. Every enabled up count pulses carry; every enabled down count pulses borrow.
- updown, step and limit may change on any cycle and take effect on that same edge.

## Timing
- Latency is 1 cycle from the sampled inputs to the q/carry/borrow update.
- carry and borrow are aligned with the new q value and last exactly one cycle unless re-triggered.
- tc and zero are combinational from q, updown and limit, with no registered delay. Cascade with en_next = en & tc.
- clr_n asserted mid-count overrides load and en on that edge. q=0 is visible the following cycle.
- load and en asserted together: load wins and no carry/borrow is generated.

## Test plan
- Reset/priority, WIDTH=4, limit=15, step=1, updown=1: count to q=5, then clr_n=0 with load=1, din=9 → q=0 next cycle, carry=0. Release → q counts 1,2,3.
- Wrap up, WIDTH=4, limit=9, step=3, from q=8: expected q sequence 1, 4, 7, 0, with carry pulsing on exactly the 8→1 and 7→0 edges.
- Wrap down, limit=9, step=3, from q=1, updown=0: expected q sequence 8, 5, 2, 9, with borrow on 1→8 and 2→9. tc=1 only while updown=0 and q==0.
- Saturate, SATURATE=1, limit=12, step=5, from q=10 up: q sequence 12, 12, with carry=1 on both edges. Switch updown=0: q sequence 7, 2, 0, 0, with borrow on 2→0 and on 0→0.
- Out of range: load din=14 with limit=9 → q=14. Next up count → q=0, carry=1. Reload din=14, down count → q=9, borrow=1.
- Hold and step=0: en=0 for 3 cycles, then en=1 with step=0 for 3 cycles → q is unchanged and carry=borrow=0 throughout.
